// File: rtl/decode_cycle.sv
// RV32I instruction-decode stage: register file with write-back bypass, control
// decoder, immediate extender and the ID/EX pipeline register feeding execute.
module decode_cycle #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            RegWriteE,
  output logic            ALUSrcE,
  output logic            MemWriteE,
  output logic            ResultSrcE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] Imm_Ext_E,
  output logic [4:0]      RD_E,
  output logic [4:0]      RS1_E,
  output logic [4:0]      RS2_E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic       funct7b5;

  assign opcode   = InstrD[6:0];
  assign rd       = InstrD[11:7];
  assign funct3   = InstrD[14:12];
  assign rs1      = InstrD[19:15];
  assign rs2      = InstrD[24:20];
  assign funct7b5 = InstrD[30];

  // Register file; entry 0 exists but is never written, so it stays zero.
  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (RegWriteW && RDW != 5'd0) begin
      regs[RDW] <= ResultW;
    end
  end

  logic [XLEN-1:0] rd1, rd2;

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != 5'd0) rd1 = (RegWriteW && RDW == rs1) ? ResultW : regs[rs1];
    if (rs2 != 5'd0) rd2 = (RegWriteW && RDW == rs2) ? ResultW : regs[rs2];
  end

  logic       reg_write, alu_src, mem_write, result_src, branch;
  logic [2:0] alu_control;
  logic [XLEN-1:0] imm_ext;
  logic [2:0] alu_arith;

  // Shared funct3 decode for R-type and I-ALU; only R-type honours funct7b5.
  always_comb begin
    alu_arith = ALU_ADD;
    case (funct3)
      3'b000:  alu_arith = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_arith = ALU_SLT;
      3'b110:  alu_arith = ALU_OR;
      3'b111:  alu_arith = ALU_AND;
      default: alu_arith = ALU_ADD;
    endcase
  end

  always_comb begin
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    mem_write   = 1'b0;
    result_src  = 1'b0;
    branch      = 1'b0;
    alu_control = ALU_ADD;
    imm_ext     = '0;
    case (opcode)
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 1'b1;
        imm_ext    = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_SW: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
        imm_ext   = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_R: begin
        reg_write   = 1'b1;
        alu_control = alu_arith;
      end
      OP_I: begin
        reg_write   = 1'b1;
        alu_src     = 1'b1;
        alu_control = alu_arith;
        imm_ext     = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_BEQ: begin
        branch      = 1'b1;
        alu_control = ALU_SUB;
        imm_ext     = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                       InstrD[30:25], InstrD[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  // ID/EX register: a flush loads an all-zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || FlushE) begin
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= 3'b000;
      RD1_E       <= '0;
      RD2_E       <= '0;
      Imm_Ext_E   <= '0;
      RD_E        <= '0;
      RS1_E       <= '0;
      RS2_E       <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      RegWriteE   <= reg_write;
      ALUSrcE     <= alu_src;
      MemWriteE   <= mem_write;
      ResultSrcE  <= result_src;
      BranchE     <= branch;
      ALUControlE <= alu_control;
      RD1_E       <= rd1;
      RD2_E       <= rd2;
      Imm_Ext_E   <= imm_ext;
      RD_E        <= rd;
      RS1_E       <= rs1;
      RS2_E       <= rs2;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: a spec-level model predicts the ID/EX contents every
// cycle, and directed vectors pin key results with hand-computed literals.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
  logic        RegWriteW = 1'b0, FlushE = 1'b0;
  logic [4:0]  RDW = '0;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E, RS1_E, RS2_E;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .RS1_E(RS1_E), .RS2_E(RS2_E), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  typedef struct packed {
    logic        rw, as, mw, rs, br;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc, pc4;
  } idex_t;

  idex_t       exp_s = '0;
  logic [31:0] mregs [32];
  idex_t       act_s;

  assign act_s = '{RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
                   RD1_E, RD2_E, Imm_Ext_E, RD_E, RS1_E, RS2_E, PCE, PCPlus4E};

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (RegWriteW && RDW == idx) return ResultW;
    return mregs[idx];
  endfunction

  function automatic logic [2:0] arith_op(input logic [31:0] i, input bit is_r);
    case (i[14:12])
      3'b000:  return (is_r && i[30]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic idex_t model_next();
    idex_t e;
    logic [31:0] i;
    int simm;
    i = InstrD;
    e = '0;
    if (FlushE) return e;
    e.rd  = i[11:7];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd1 = model_read(i[19:15]);
    e.rd2 = model_read(i[24:20]);
    e.pc  = PCD;
    e.pc4 = PCPlus4D;
    case (i[6:0])
      7'b0000011: begin
        {e.rw, e.as, e.mw, e.rs, e.br} = 5'b11010;
        simm = $signed(i[31:20]);
        e.imm = simm;
      end
      7'b0100011: begin
        {e.rw, e.as, e.mw, e.rs, e.br} = 5'b01100;
        simm = $signed({i[31:25], i[11:7]});
        e.imm = simm;
      end
      7'b0110011: begin
        {e.rw, e.as, e.mw, e.rs, e.br} = 5'b10000;
        e.alu = arith_op(i, 1'b1);
      end
      7'b0010011: begin
        {e.rw, e.as, e.mw, e.rs, e.br} = 5'b11000;
        e.alu = arith_op(i, 1'b0);
        simm = $signed(i[31:20]);
        e.imm = simm;
      end
      7'b1100011: begin
        {e.rw, e.as, e.mw, e.rs, e.br} = 5'b00001;
        e.alu = 3'b001;
        simm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
        e.imm = simm;
      end
      default: e.imm = '0;
    endcase
    return e;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_s <= '0;
      for (int k = 0; k < 32; k++) mregs[k] <= '0;
    end else begin
      exp_s <= model_next();
      if (RegWriteW && RDW != 0) mregs[RDW] <= ResultW;
    end
  end

  // Every cycle out of reset the whole ID/EX image must match the model.
  always @(negedge clk) begin
    if (rst) begin
      tests++;
      if (act_s !== exp_s) begin
        fails++;
        $display("FAIL idex_model t=%0t actual=%h required=%h", $time, act_s, exp_s);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic [31:0] pc = 32'h0000_1000;

  // Called at a negedge: apply inputs, return at the negedge after they are captured.
  task automatic drive(input logic [31:0] instr, input logic wb, input logic [4:0] rdw,
                       input logic [31:0] res, input logic flush);
    InstrD    = instr;
    RegWriteW = wb;
    RDW       = rdw;
    ResultW   = res;
    FlushE    = flush;
    PCD       = pc;
    PCPlus4D  = pc + 32'd4;
    pc        = pc + 32'd4;
    @(negedge clk);
  endtask

  localparam logic [31:0] ADD_3_5_5  = 32'h005281B3;
  localparam logic [31:0] SUB_1_2_7  = 32'h407100B3;
  localparam logic [31:0] LW_4_M4_2  = 32'hFFC12203;
  localparam logic [31:0] SW_6_8_2   = 32'h00612423;
  localparam logic [31:0] BEQ_1_2_M8 = 32'hFE208CE3;
  localparam logic [31:0] ADD_10_9_0 = 32'h00048533;
  localparam logic [31:0] ADD_11_0_0 = 32'h000005B3;
  localparam logic [31:0] ANDI_1_2_7 = 32'h00717093;
  localparam logic [31:0] OR_1_2_3   = 32'h003160B3;
  localparam logic [31:0] SLT_1_2_3  = 32'h003120B3;
  localparam logic [31:0] ADDI_1024  = 32'h40010093;
  localparam logic [31:0] ILLEGAL    = 32'hFFFFFFFF;

  logic [31:0] pool [8];

  initial begin
    pool = '{ADD_3_5_5, SUB_1_2_7, LW_4_M4_2, SW_6_8_2, BEQ_1_2_M8,
             ANDI_1_2_7, SLT_1_2_3, ILLEGAL};

    #1;
    check("reset_outputs_zero", 32'(|act_s), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    drive(ADD_3_5_5, 1'b0, 5'd0, 32'd0, 1'b0);
    check("x5_after_reset", RD1_E, 32'd0);

    drive(32'd0, 1'b1, 5'd5, 32'h0000_00AA, 1'b0);
    drive(ADD_3_5_5, 1'b0, 5'd0, 32'd0, 1'b0);
    check("add_rd1", RD1_E, 32'hAA);
    check("add_rd2", RD2_E, 32'hAA);
    check("add_regwrite", 32'(RegWriteE), 32'd1);
    check("add_aluctl", 32'(ALUControlE), 32'd0);
    check("add_rd", 32'(RD_E), 32'd3);

    drive(SUB_1_2_7, 1'b1, 5'd7, 32'h0000_1234, 1'b0);
    check("bypass_rd2", RD2_E, 32'h1234);
    check("sub_aluctl", 32'(ALUControlE), 32'd1);

    drive(LW_4_M4_2, 1'b0, 5'd0, 32'd0, 1'b0);
    check("lw_imm", Imm_Ext_E, 32'hFFFF_FFFC);
    check("lw_ctl", 32'({ResultSrcE, ALUSrcE}), 32'd3);

    drive(SW_6_8_2, 1'b0, 5'd0, 32'd0, 1'b0);
    check("sw_imm", Imm_Ext_E, 32'd8);
    check("sw_ctl", 32'({MemWriteE, RegWriteE}), 32'b10);

    drive(BEQ_1_2_M8, 1'b0, 5'd0, 32'd0, 1'b0);
    check("beq_imm", Imm_Ext_E, 32'hFFFF_FFF8);
    check("beq_ctl", 32'({BranchE, ALUControlE}), 32'b1001);

    drive(ANDI_1_2_7, 1'b0, 5'd0, 32'd0, 1'b0);
    check("andi_aluctl", 32'(ALUControlE), 32'b010);
    drive(OR_1_2_3, 1'b0, 5'd0, 32'd0, 1'b0);
    check("or_aluctl", 32'(ALUControlE), 32'b011);
    drive(SLT_1_2_3, 1'b0, 5'd0, 32'd0, 1'b0);
    check("slt_aluctl", 32'(ALUControlE), 32'b101);
    drive(ADDI_1024, 1'b0, 5'd0, 32'd0, 1'b0);
    check("addi_bit30_is_add", 32'(ALUControlE), 32'd0);
    check("addi_imm", Imm_Ext_E, 32'h400);

    drive(SUB_1_2_7, 1'b1, 5'd9, 32'h0000_9999, 1'b1);
    check("flush_ctl", 32'({RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE}), 32'd0);
    check("flush_rd", 32'(RD_E), 32'd0);
    check("flush_pc", PCE, 32'd0);
    drive(ADD_10_9_0, 1'b0, 5'd0, 32'd0, 1'b0);
    check("flush_wb_landed", RD1_E, 32'h9999);

    drive(32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    drive(ADD_11_0_0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    check("x0_rd1", RD1_E, 32'd0);
    check("x0_rd2", RD2_E, 32'd0);

    drive(ILLEGAL, 1'b0, 5'd0, 32'd0, 1'b0);
    check("illegal_ctl", 32'({RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE}), 32'd0);
    check("illegal_imm", Imm_Ext_E, 32'd0);

    // Mixed traffic with random write-backs; the model checks each cycle.
    for (int n = 0; n < 60; n++) begin
      drive(pool[$urandom_range(0, 7)] ^ {7'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 15'd0},
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 7) == 0));
    end

    InstrD = ADD_3_5_5;
    RegWriteW = 1'b0;
    FlushE = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset_mid_cycle", 32'(|act_s), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(ADD_3_5_5, 1'b0, 5'd0, 32'd0, 1'b0);
    check("x5_cleared_by_reset", RD1_E, 32'd0);
    check("x5_cleared_rs2", RD2_E, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
Instruction-decode stage of the five-stage RV32I pipeline. It sits between fetch and execute and contains:
- the 32x32 register file, with write-back bypass,
- the main/ALU control decoder,
- the immediate extender,
- the ID/EX pipeline register that drives the execute stage.

It also exports the source register indices that the hazard unit uses to generate the ForwardA_E and ForwardB_E selects.

Parameters:
XLEN, 32, datapath width
NREG, 32, number of architectural registers (index width 5)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
InstrD  in  32  instruction from the IF/ID register
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
RegWriteW  in  1  write-back enable
RDW  in  5  write-back destination
ResultW  in  32  write-back data
FlushE  in  1  load bubble into ID/EX (taken branch or load-use)
RegWriteE  out  1  registered control
ALUSrcE  out  1  1 = immediate operand
MemWriteE  out  1  store enable
ResultSrcE  out  1  1 = load data selected at write-back
BranchE  out  1  beq
ALUControlE  out  3  ALU operation
RD1_E  out  32  rs1 data
RD2_E  out  32  rs2 data
Imm_Ext_E  out  32  sign-extended immediate
RD_E  out  5  rd
RS1_E  out  5  rs1 index
RS2_E  out  5  rs2 index
PCE  out  32  registered PCD
PCPlus4E  out  32  registered PCPlus4D

Behaviour:
- Field extraction: opcode = InstrD[6:0], rd = [11:7], funct3 = [14:12], rs1 = [19:15], rs2 = [24:20], funct7b5 = [30].
- Main decode (RegWrite, ALUSrc, MemWrite, ResultSrc, Branch):
  - 0000011 lw: 1,1,0,1,0
  - 0100011 sw: 0,1,1,0,0
  - 0110011 R-type: 1,0,0,0,0
  - 0010011 I-ALU: 1,1,0,0,0
  - 1100011 beq: 0,0,0,0,1
  - any other opcode: all 0, immediate 0 (acts as NOP).
- ALUControl encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt.
  - lw and sw → add.
  - beq → sub.
  - R-type and I-ALU, by funct3:
    - 000 → sub when opcode = R-type and funct7b5 = 1, else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - other → add.
- Immediates, all sign-extended from InstrD[31]:
  - I-type (lw, I-ALU): {20×[31], [31:20]}
  - S-type: {20×[31], [31:25], [11:7]}
  - B-type: {19×[31], [31], [7], [30:25], [11:8], 0}
- Register file:
  - Two combinational read ports, one write port.
  - Write occurs at posedge clk when RegWriteW = 1 and RDW ≠ 0.
  - x0 always reads 0; writes to x0 are ignored.
  - Same-cycle bypass: if RegWriteW = 1, RDW ≠ 0 and RDW equals the read index, the read port returns ResultW (not the stale entry).
  - All registers clear to 0 on reset.
- ID/EX register:
  - Updates at posedge clk; decode-to-execute latency is 1 cycle.
  - FlushE = 1 at the edge: RegWriteE, MemWriteE, BranchE, ResultSrcE and ALUSrcE become 0, ALUControlE becomes 000, RD_E, RS1_E and RS2_E become 0, and all data fields become 0.
  - A flush is a pure bubble. Register-file writes in the same cycle still occur.
  - No stall input: the hazard unit holds IF/ID, and a load-use hazard is resolved by FlushE.
- Reset (rst = 0, asynchronous): every output is 0 immediately, independent of clk, including a reset asserted mid-pipeline. Operation resumes at the first posedge after rst rises.
- Write-back of x0 combined with a read of x0: the read returns 0; no bypass applies.

Test Plan:
- Reset: drive rst = 0 mid-cycle → all outputs 0 with no clock edge; after release, reading x5 returns 0.
- Write then read:
  - Write x5 = 0x0000_00AA (RegWriteW = 1, RDW = 5).
  - Next cycle InstrD = add x3,x5,x5 (0x005281B3) → one edge later RD1_E = RD2_E = 0xAA, RegWriteE = 1, ALUControlE = 000, RD_E = 3.
- Same-cycle bypass: InstrD = sub x1,x2,x7 while RDW = 7, ResultW = 0x1234, RegWriteW = 1 → RD2_E = 0x1234, ALUControlE = 001.
- Immediates:
  - lw x4,-4(x2) → Imm_Ext_E = 0xFFFF_FFFC, ResultSrcE = 1, ALUSrcE = 1.
  - sw x6,8(x2) → Imm_Ext_E = 8, MemWriteE = 1, RegWriteE = 0.
  - beq x1,x2,-8 → Imm_Ext_E = 0xFFFF_FFF8, BranchE = 1, ALUControlE = 001.
- Flush: valid R-type instruction in decode with FlushE = 1 → next edge all controls 0 and RD_E = 0; a simultaneous write-back to x9 still lands (verified by reading x9 afterwards).
- x0 and illegal opcode:
  - Write x0 = 0xFFFF_FFFF with RegWriteW = 1 → a later read of x0 returns 0.
  - Opcode 1111111 → all controls 0 and Imm_Ext_E = 0.
